// File: rtl/rst_drain_marker_q.sv
`default_nettype none
// ============================================================================
// Module      : rst_drain_marker_q
// Description : Write-domain flush/reset marker tracker for an asynchronous
//               FIFO. Every flush request records the current write pointer
//               in a small circular queue. The read side stays blocked until
//               the synchronised read pointer reaches the head marker. A
//               programmable guard interval follows each marker before the
//               next marker is serviced or the read side is released.
// Ports       : clk_w      - write-domain clock (posedge)
//               rst_w      - asynchronous active-high reset
//               flush_req  - single-cycle request to mark the current wptr
//               wptr       - write pointer (clk_w domain)
//               rptr_sync  - read pointer already synchronised into clk_w
//               marker     - head pending marker, DEPTH-1 when queue empty
//               mrk_valid  - queue non-empty
//               mrk_count  - number of queued markers
//               rd_block   - read side must be held
//               flush_done - one-cycle pulse when drain and guard complete
//               mrk_ovf    - sticky: a request was dropped on a full queue
// Revision    : 1.0 - initial release
// ============================================================================
module rst_drain_marker_q #(
  parameter int PTRSIZE   = 10,
  parameter int DEPTH     = 1024,
  parameter int MRK_DEPTH = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic                               clk_w,
  input  logic                               rst_w,
  input  logic                               flush_req,
  input  logic [PTRSIZE-1:0]                 wptr,
  input  logic [PTRSIZE-1:0]                 rptr_sync,
  output logic [PTRSIZE-1:0]                 marker,
  output logic                               mrk_valid,
  output logic [$clog2(MRK_DEPTH+1)-1:0]     mrk_count,
  output logic                               rd_block,
  output logic                               flush_done,
  output logic                               mrk_ovf
);

  localparam int IW = (MRK_DEPTH > 1) ? $clog2(MRK_DEPTH) : 1;
  localparam int CW = $clog2(MRK_DEPTH + 1);
  localparam int GW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [PTRSIZE-1:0] C_IDLE_MRK   = PTRSIZE'(DEPTH - 1);
  localparam logic [IW-1:0]      C_LAST_IDX   = IW'(MRK_DEPTH - 1);
  localparam logic [CW-1:0]      C_FULL_CNT   = CW'(MRK_DEPTH);
  localparam logic [GW-1:0]      C_GUARD_INIT = (HOLD_CYC > 0) ? GW'(HOLD_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  logic [PTRSIZE-1:0] mem_q [MRK_DEPTH];
  logic [IW-1:0]      head_q, tail_q;
  logic [CW-1:0]      count_q, count_d;
  state_t             state_q, state_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic               done_q, done_d;
  logic               ovf_q;

  logic [IW-1:0]      w_tail_prev;
  logic               w_coalesce, w_full, w_push, w_drop, w_pop;

  // Indices wrap explicitly so non-power-of-two queue depths work.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    return (idx == C_LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    w_tail_prev = (tail_q == '0) ? C_LAST_IDX : tail_q - 1'b1;
    // A repeated request for the pointer already at the tail adds nothing.
    w_coalesce  = (count_q != '0) && (mem_q[w_tail_prev] == wptr);
    w_full      = (count_q == C_FULL_CNT);
    w_push      = flush_req && !w_coalesce && !w_full;
    w_drop      = flush_req && !w_coalesce && w_full;
    // Equality only: pointers wrap freely, so no ordering can be assumed.
    w_pop       = (state_q == S_DRAIN) && (count_q != '0) &&
                  (rptr_sync == mem_q[head_q]);
    count_d     = count_q + CW'(w_push) - CW'(w_pop);
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop) begin
          if (HOLD_CYC == 0) begin
            done_d  = 1'b1;
            // A same-edge push keeps the drain going without an IDLE bubble.
            state_d = (count_d != '0) ? S_DRAIN : S_IDLE;
          end else begin
            state_d = S_GUARD;
            guard_d = C_GUARD_INIT;
          end
        end
      end
      S_GUARD: begin
        if (guard_q == '0) begin
          done_d  = 1'b1;
          state_d = (count_q != '0) ? S_DRAIN : S_IDLE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      for (int i = 0; i < MRK_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      guard_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (w_push) begin
        mem_q[tail_q] <= wptr;
        tail_q        <= idx_inc(tail_q);
      end
      if (w_pop) head_q <= idx_inc(head_q);
      count_q <= count_d;
      state_q <= state_d;
      guard_q <= guard_d;
      done_q  <= done_d;
      ovf_q   <= ovf_q | w_drop;
    end
  end

  assign marker     = (count_q != '0) ? mem_q[head_q] : C_IDLE_MRK;
  assign mrk_valid  = (count_q != '0);
  assign mrk_count  = count_q;
  assign rd_block   = (state_q != S_IDLE) || (count_q != '0);
  assign flush_done = done_q;
  assign mrk_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_drain_marker_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_drain_marker_q
// Description : Directed bench for rst_drain_marker_q. Two instances share
//               stimulus: one with a two-cycle guard, one with no guard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_drain_marker_q;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_req;
  logic [9:0] wptr, rptr_sync;

  logic [9:0] mk2, mk0;
  logic       mv2, mv0, rb2, rb0, fd2, fd0, ov2, ov0;
  logic [2:0] mc2, mc0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rst_drain_marker_q #(.PTRSIZE(10), .DEPTH(1024), .MRK_DEPTH(4), .HOLD_CYC(2)) u_dut2 (
    .clk_w(clk), .rst_w(rst), .flush_req(flush_req), .wptr(wptr), .rptr_sync(rptr_sync),
    .marker(mk2), .mrk_valid(mv2), .mrk_count(mc2), .rd_block(rb2),
    .flush_done(fd2), .mrk_ovf(ov2)
  );

  rst_drain_marker_q #(.PTRSIZE(10), .DEPTH(1024), .MRK_DEPTH(4), .HOLD_CYC(0)) u_dut0 (
    .clk_w(clk), .rst_w(rst), .flush_req(flush_req), .wptr(wptr), .rptr_sync(rptr_sync),
    .marker(mk0), .mrk_valid(mv0), .mrk_count(mc0), .rd_block(rb0),
    .flush_done(fd0), .mrk_ovf(ov0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rv [8] = '{1021, 1022, 1023, 0, 1, 2, 3, 4};

    // ---------------- reset and idle ----------------
    rst = 1'b1; flush_req = 1'b0; wptr = '0; rptr_sync = '0;
    tick();
    chk("rst_marker",  mk2, 1023);
    chk("rst_count",   mc2, 0);
    chk("rst_valid",   mv2, 0);
    chk("rst_rdblock", rb2, 0);
    chk("rst_done",    fd2, 0);
    chk("rst_ovf",     ov2, 0);
    rst = 1'b0;

    // ---------------- empty-FIFO flush at 37 ----------------
    wptr = 10'd37; rptr_sync = 10'd37; flush_req = 1'b1;
    tick();                                   // edge 0
    flush_req = 1'b0;
    chk("e0_marker",  mk2, 37);
    chk("e0_count",   mc2, 1);
    chk("e0_rdblock", rb2, 1);
    chk("e0_valid",   mv2, 1);
    tick();                                   // edge 1
    chk("e1_rdblock", rb2, 1);
    chk("e1_marker",  mk2, 37);
    tick();                                   // edge 2: pop
    chk("e2_marker",  mk2, 1023);
    chk("e2_rdblock", rb2, 1);
    chk("e2_done",    fd2, 0);
    chk("h0_e2_done", fd0, 1);
    chk("h0_e2_rdblock", rb0, 0);
    tick();                                   // edge 3
    chk("e3_rdblock", rb2, 1);
    chk("e3_done",    fd2, 0);
    chk("h0_e3_done", fd0, 0);
    tick();                                   // edge 4: guard ends
    chk("e4_rdblock", rb2, 0);
    chk("e4_done",    fd2, 1);
    tick();
    chk("e5_done",    fd2, 0);

    // ---------------- drain across pointer wrap ----------------
    rptr_sync = 10'd1020; wptr = 10'd5; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    foreach (rv[i]) begin
      rptr_sync = 10'(rv[i]);
      tick();
      chk("wrap_hold_rdblock", rb2, 1);
      chk("wrap_hold_count",   mc2, 1);
    end
    rptr_sync = 10'd5;
    tick();                                   // pop at 5
    chk("wrap_pop_count",   mc2, 0);
    chk("wrap_pop_rdblock", rb2, 1);
    tick();
    chk("wrap_guard_rdblock", rb2, 1);
    tick();
    chk("wrap_rel_rdblock", rb2, 0);
    chk("wrap_rel_done",    fd2, 1);

    // ---------------- three queued markers ----------------
    rptr_sync = 10'd0;
    flush_req = 1'b1; wptr = 10'd100; tick();
    wptr = 10'd200; tick();
    wptr = 10'd300; tick();
    flush_req = 1'b0;
    chk("multi_count",  mc2, 3);
    chk("multi_head0",  mk2, 100);
    rptr_sync = 10'd100;
    tick();                                   // pop 100
    chk("multi_head1",  mk2, 200);
    chk("multi_count1", mc2, 2);
    chk("multi_rb_a",   rb2, 1);
    tick();
    chk("multi_rb_b",   rb2, 1);
    tick();                                   // guard done, next marker
    chk("multi_done1",  fd2, 1);
    chk("multi_rb_c",   rb2, 1);
    rptr_sync = 10'd200;
    tick();                                   // pop 200
    chk("multi_head2",  mk2, 300);
    chk("multi_gap_done", fd2, 0);
    tick();
    chk("multi_rb_d",   rb2, 1);
    tick();
    chk("multi_done2",  fd2, 1);
    rptr_sync = 10'd300;
    tick();                                   // pop 300
    chk("multi_empty_marker", mk2, 1023);
    chk("multi_rb_e",   rb2, 1);
    tick();
    chk("multi_rb_f",   rb2, 1);
    tick();
    chk("multi_done3",  fd2, 1);
    chk("multi_rel",    rb2, 0);

    // ---------------- coalesce and overflow ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    rptr_sync = 10'd999;
    flush_req = 1'b1; wptr = 10'd50; tick();
    tick();                                   // same wptr again
    flush_req = 1'b0;
    chk("coal_count", mc2, 1);
    chk("coal_ovf",   ov2, 0);
    flush_req = 1'b1;
    wptr = 10'd51; tick();
    wptr = 10'd52; tick();
    wptr = 10'd53; tick();
    chk("full_count", mc2, 4);
    chk("full_ovf0",  ov2, 0);
    wptr = 10'd54; tick();                    // dropped
    flush_req = 1'b0;
    chk("ovf_count",  mc2, 4);
    chk("ovf_set",    ov2, 1);
    chk("ovf_head",   mk2, 50);
    tick();
    chk("ovf_sticky", ov2, 1);

    // ---------------- asynchronous reset mid-cycle ----------------
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count",   mc2, 0);
    chk("arst_marker",  mk2, 1023);
    chk("arst_ovf",     ov2, 0);
    chk("arst_rdblock", rb2, 0);
    rst = 1'b0;
    tick();
    chk("arst_post_done", fd2, 0);

    // ---------------- simultaneous pop and push ----------------
    rptr_sync = 10'd0; wptr = 10'd70; flush_req = 1'b1;
    tick();                                   // push 70
    flush_req = 1'b0;
    tick();                                   // into DRAIN
    rptr_sync = 10'd70; wptr = 10'd80; flush_req = 1'b1;
    tick();                                   // pop 70 + push 80
    flush_req = 1'b0; rptr_sync = 10'd0;
    chk("pp_h0_count",  mc0, 1);
    chk("pp_h0_marker", mk0, 80);
    chk("pp_h0_done",   fd0, 1);
    chk("pp_h0_rb",     rb0, 1);
    chk("pp_h2_count",  mc2, 1);
    chk("pp_h2_marker", mk2, 80);
    tick();
    chk("pp_h0_done_once", fd0, 0);
    chk("pp_h0_count2",    mc0, 1);
    chk("pp_h0_rb2",       rb0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
